// File: rtl/rgb_fade_ctrl.sv
// rgb_fade_ctrl: per-LED colour targets that the outputs either jump to
// or ramp toward one step per timebase tick; feeds the PL9823 driver.
module rgb_fade_ctrl #(
  parameter int TICK_DIV = 500000,
  parameter int STEP     = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD_VALID,
  output logic       LOAD_READY,
  input  logic [1:0] LOAD_LED,
  input  logic [7:0] LOAD_ROT,
  input  logic [7:0] LOAD_GRUEN,
  input  logic [7:0] LOAD_BLAU,
  input  logic       FADE_EN,
  output logic [7:0] D1_ROT,
  output logic [7:0] D1_GRUEN,
  output logic [7:0] D1_BLAU,
  output logic [7:0] D2_ROT,
  output logic [7:0] D2_GRUEN,
  output logic [7:0] D2_BLAU,
  output logic [7:0] D3_ROT,
  output logic [7:0] D3_GRUEN,
  output logic [7:0] D3_BLAU,
  output logic       BUSY,
  output logic       DONE
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [7:0] STEP8 = 8'(STEP);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_FADING = 1'b1;

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_ready;
  logic          r_done;
  logic [1:0]    r_jmp;
  logic [7:0]    r_tgt [9];
  logic [7:0]    r_cur [9];

  logic       w_tick;
  logic       w_accept;
  logic       w_diff;
  logic       w_all_eq;
  logic [8:0] w_sel;
  logic [7:0] w_load [3];
  logic [7:0] w_tgt_nxt [9];
  logic [7:0] w_cur_nxt [9];

  // Magnitude compare is the unsigned form of the signed 9-bit difference
  function automatic logic [7:0] f_step(
    input logic [7:0] cur,
    input logic [7:0] tgt
  );
    logic [8:0] d;
    f_step = tgt;
    if (tgt > cur) begin
      d = {1'b0, tgt} - {1'b0, cur};
      if (d > STEP9) f_step = cur + STEP8;
    end else begin
      d = {1'b0, cur} - {1'b0, tgt};
      if (d > STEP9) f_step = cur - STEP8;
    end
  endfunction

  assign w_tick   = (r_cnt == TICK_LAST);
  assign w_accept = LOAD_VALID && r_ready;

  always_comb begin
    w_load[0] = LOAD_ROT;
    w_load[1] = LOAD_GRUEN;
    w_load[2] = LOAD_BLAU;
    w_diff    = 1'b0;
    w_all_eq  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      w_sel[i] = w_accept && (LOAD_LED == 2'(i / 3 + 1));
      w_tgt_nxt[i] = w_sel[i] ? w_load[i % 3] : r_tgt[i];
      w_cur_nxt[i] = r_cur[i];
      if (r_state == S_FADING) begin
        if (!FADE_EN) w_cur_nxt[i] = w_tgt_nxt[i];
        else if (w_tick) w_cur_nxt[i] = f_step(r_cur[i], r_tgt[i]);
      end else if (r_jmp == 2'(i / 3 + 1)) begin
        w_cur_nxt[i] = r_tgt[i];
      end
      if (w_sel[i] && (w_tgt_nxt[i] != r_cur[i])) w_diff = 1'b1;
      if (w_cur_nxt[i] != w_tgt_nxt[i]) w_all_eq = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_jmp   <= 2'd0;
      for (int i = 0; i < 9; i++) begin
        r_tgt[i] <= 8'd0;
        r_cur[i] <= 8'd0;
      end
    end else begin
      r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
      r_ready <= ~w_accept;
      r_done  <= 1'b0;
      r_jmp   <= 2'd0;
      for (int i = 0; i < 9; i++) begin
        r_tgt[i] <= w_tgt_nxt[i];
        r_cur[i] <= w_cur_nxt[i];
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept && (LOAD_LED != 2'd0)) begin
            if (!FADE_EN) r_jmp <= LOAD_LED;
            else if (w_diff) r_state <= S_FADING;
          end
        end
        S_FADING: begin
          if (!FADE_EN || (w_tick && w_all_eq)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign LOAD_READY = r_ready;
  assign BUSY       = (r_state == S_FADING);
  assign DONE       = r_done;
  assign D1_ROT     = r_cur[0];
  assign D1_GRUEN   = r_cur[1];
  assign D1_BLAU    = r_cur[2];
  assign D2_ROT     = r_cur[3];
  assign D2_GRUEN   = r_cur[4];
  assign D2_BLAU    = r_cur[5];
  assign D3_ROT     = r_cur[6];
  assign D3_GRUEN   = r_cur[7];
  assign D3_BLAU    = r_cur[8];

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Bench for rgb_fade_ctrl: per-cycle reference model compare plus
// directed scenarios with hand-computed literal expectations.
module tb_rgb_fade_ctrl;
  localparam int TDIV = 10;
  localparam int STP  = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       LOAD_VALID = 1'b0;
  logic       LOAD_READY;
  logic [1:0] LOAD_LED = 2'd0;
  logic [7:0] LOAD_ROT = 8'd0;
  logic [7:0] LOAD_GRUEN = 8'd0;
  logic [7:0] LOAD_BLAU = 8'd0;
  logic       FADE_EN = 1'b0;
  logic [7:0] D1_ROT, D1_GRUEN, D1_BLAU;
  logic [7:0] D2_ROT, D2_GRUEN, D2_BLAU;
  logic [7:0] D3_ROT, D3_GRUEN, D3_BLAU;
  logic       BUSY, DONE;

  rgb_fade_ctrl #(.TICK_DIV(TDIV), .STEP(STP)) dut (
    .CLK(CLK), .RST(RST),
    .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
    .LOAD_LED(LOAD_LED), .LOAD_ROT(LOAD_ROT),
    .LOAD_GRUEN(LOAD_GRUEN), .LOAD_BLAU(LOAD_BLAU),
    .FADE_EN(FADE_EN),
    .D1_ROT(D1_ROT), .D1_GRUEN(D1_GRUEN), .D1_BLAU(D1_BLAU),
    .D2_ROT(D2_ROT), .D2_GRUEN(D2_GRUEN), .D2_BLAU(D2_BLAU),
    .D3_ROT(D3_ROT), .D3_GRUEN(D3_GRUEN), .D3_BLAU(D3_BLAU),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int get_d(input int idx);
    case (idx)
      0: return int'(D1_ROT);
      1: return int'(D1_GRUEN);
      2: return int'(D1_BLAU);
      3: return int'(D2_ROT);
      4: return int'(D2_GRUEN);
      5: return int'(D2_BLAU);
      6: return int'(D3_ROT);
      7: return int'(D3_GRUEN);
      8: return int'(D3_BLAU);
      default: return -1;
    endcase
  endfunction

  // Reference model: colour LED l channel c lives at index (l-1)*3+c
  int m_tgt [9];
  int m_cur [9];
  int o_t   [9];
  int m_cnt, m_jmp, led;
  bit m_busy, m_done, m_ready, m_valid, acc, tick, eq;

  function automatic int approach(input int c, input int t);
    if (t - c > STP) return c + STP;
    if (c - t > STP) return c - STP;
    return t;
  endfunction

  initial begin
    m_valid = 1'b0;
    forever begin
      @(posedge CLK);
      if (RST) begin
        for (int i = 0; i < 9; i++) begin
          m_tgt[i] = 0;
          m_cur[i] = 0;
        end
        m_busy = 0; m_done = 0; m_ready = 1;
        m_cnt = 0; m_jmp = 0; m_valid = 1;
      end else begin
        acc  = LOAD_VALID && m_ready;
        led  = acc ? int'(LOAD_LED) : 0;
        tick = (m_cnt == TDIV - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        if (m_jmp != 0) begin
          for (int c = 0; c < 3; c++)
            m_cur[(m_jmp-1)*3+c] = m_tgt[(m_jmp-1)*3+c];
          m_jmp = 0;
        end
        o_t = m_tgt;
        if (led != 0) begin
          m_tgt[(led-1)*3]   = int'(LOAD_ROT);
          m_tgt[(led-1)*3+1] = int'(LOAD_GRUEN);
          m_tgt[(led-1)*3+2] = int'(LOAD_BLAU);
        end
        m_done = 0;
        if (m_busy) begin
          if (!FADE_EN) begin
            m_cur = m_tgt;
            m_busy = 0; m_done = 1;
          end else if (tick) begin
            eq = 1;
            for (int i = 0; i < 9; i++) begin
              m_cur[i] = approach(m_cur[i], o_t[i]);
              if (m_cur[i] != m_tgt[i]) eq = 0;
            end
            if (eq) begin
              m_busy = 0; m_done = 1;
            end
          end
        end else if (led != 0) begin
          if (!FADE_EN) m_jmp = led;
          else
            for (int c = 0; c < 3; c++)
              if (m_tgt[(led-1)*3+c] != m_cur[(led-1)*3+c]) m_busy = 1;
        end
        m_ready = !acc;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (m_valid) begin
        for (int i = 0; i < 9; i++)
          chk($sformatf("model_d%0d", i), get_d(i), m_cur[i]);
        chk("model_ready", int'(LOAD_READY), int'(m_ready));
        chk("model_busy", int'(BUSY), int'(m_busy));
        chk("model_done", int'(DONE), int'(m_done));
      end
    end
  end

  int q_vals[$];
  int n_done;
  int n_busy_low;

  function automatic int qv(input int i);
    if (i < q_vals.size()) return q_vals[i];
    return -1;
  endfunction

  task automatic load(input int l, input int r, input int g,
                      input int b, input bit fe);
    @(negedge CLK);
    for (int k = 0; k < 10 && !LOAD_READY; k++) @(negedge CLK);
    if (!LOAD_READY) chk("load_ready_wait", 0, 1);
    LOAD_VALID = 1'b1;
    LOAD_LED   = 2'(l);
    LOAD_ROT   = 8'(r);
    LOAD_GRUEN = 8'(g);
    LOAD_BLAU  = 8'(b);
    FADE_EN    = fe;
    @(negedge CLK);
    LOAD_VALID = 1'b0;
  endtask

  // Record each new value of one output, plus DONE pulses and BUSY drops
  task automatic watch(input int idx, input int ncyc, input int stop_n);
    int prev;
    prev = get_d(idx);
    q_vals.delete();
    for (int k = 0; k < ncyc; k++) begin
      @(negedge CLK);
      if (DONE) n_done++;
      if (!BUSY && n_done == 0) n_busy_low++;
      if (get_d(idx) != prev) begin
        prev = get_d(idx);
        q_vals.push_back(prev);
        if (stop_n != 0 && q_vals.size() == stop_n) break;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 9; i++) chk($sformatf("rst_d%0d", i), get_d(i), 0);
    chk("rst_ready", int'(LOAD_READY), 1);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);

    load(2, 8'h12, 8'h34, 8'h56, 1'b0);
    chk("jump_ready_low", int'(LOAD_READY), 0);
    @(negedge CLK);
    chk("jump_d2r", int'(D2_ROT), 8'h12);
    chk("jump_d2g", int'(D2_GRUEN), 8'h34);
    chk("jump_d2b", int'(D2_BLAU), 8'h56);
    chk("jump_d1r", int'(D1_ROT), 0);
    chk("jump_d3b", int'(D3_BLAU), 0);
    chk("jump_ready_back", int'(LOAD_READY), 1);
    chk("jump_busy", int'(BUSY), 0);

    n_done = 0;
    load(1, 8'h0A, 0, 0, 1'b1);
    watch(0, 40, 0);
    chk("up_n", q_vals.size(), 3);
    chk("up_0", qv(0), 4);
    chk("up_1", qv(1), 8);
    chk("up_2", qv(2), 10);
    chk("up_done", n_done, 1);
    chk("up_busy_after", int'(BUSY), 0);

    load(3, 0, 0, 8'h02, 1'b0);
    n_done = 0;
    load(3, 0, 0, 8'h00, 1'b1);
    watch(8, 25, 0);
    chk("down_n", q_vals.size(), 1);
    chk("down_0", qv(0), 0);
    chk("down_done", n_done, 1);
    load(3, 0, 0, 8'hFD, 1'b0);
    load(3, 0, 0, 8'hFF, 1'b1);
    watch(8, 25, 0);
    chk("top_n", q_vals.size(), 1);
    chk("top_0", qv(0), 255);

    load(2, 0, 0, 0, 1'b0);
    load(2, 8'h40, 0, 0, 1'b1);
    n_done = 0;
    n_busy_low = 0;
    watch(3, 30, 2);
    chk("rt_a0", qv(0), 4);
    chk("rt_a1", qv(1), 8);
    load(2, 0, 0, 0, 1'b1);
    watch(3, 40, 0);
    chk("rt_n", q_vals.size(), 2);
    chk("rt_b0", qv(0), 4);
    chk("rt_b1", qv(1), 0);
    chk("rt_done", n_done, 1);
    chk("rt_busy_high", n_busy_low, 0);

    load(1, 8'h80, 8'h80, 8'h80, 1'b1);
    watch(0, 15, 1);
    chk("abort_step", qv(0), 14);
    FADE_EN = 1'b0;
    @(negedge CLK);
    chk("abort_r", int'(D1_ROT), 8'h80);
    chk("abort_g", int'(D1_GRUEN), 8'h80);
    chk("abort_b", int'(D1_BLAU), 8'h80);
    chk("abort_done", int'(DONE), 1);
    chk("abort_busy", int'(BUSY), 0);

    load(0, 8'h11, 8'h22, 8'h33, 1'b0);
    repeat (3) @(negedge CLK);
    chk("led0_d1r", int'(D1_ROT), 8'h80);

    load(3, 8'h20, 0, 8'hFF, 1'b1);
    watch(6, 15, 1);
    chk("coin_first", qv(0), 4);
    repeat (8) @(negedge CLK);
    load(3, 0, 0, 8'hFF, 1'b1);
    chk("coin_old_tgt", int'(D3_ROT), 8);
    watch(6, 30, 0);
    chk("coin_n", q_vals.size(), 2);
    chk("coin_0", qv(0), 4);
    chk("coin_1", qv(1), 0);

    load(2, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    repeat (15) @(negedge CLK);
    chk("mid_busy", int'(BUSY), 1);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_d2r", int'(D2_ROT), 0);
    chk("mid_rst_busy", int'(BUSY), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 9; i++) chk($sformatf("rst2_d%0d", i), get_d(i), 0);
    chk("rst2_ready", int'(LOAD_READY), 1);
    chk("rst2_busy", int'(BUSY), 0);
    chk("rst2_done", int'(DONE), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
